// File: rtl/uart_word_tx.sv
// uart_word_tx: buffers words from the core in a small FIFO and serialises
// each one as two bytes (low byte first) toward a UART byte transmitter.
// It also keeps a running count of words whose high byte has been accepted.
module uart_word_tx #(
   parameter int WORD_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  word_valid,
   input  logic [WORD_WIDTH-1:0] word_in,
   output logic                  word_ready,
   output logic                  tx_byte_valid,
   output logic [7:0]            tx_byte,
   input  logic                  tx_byte_ready,
   output logic                  word_sent,
   output logic [WORD_WIDTH-1:0] word_sent_count
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOW,
      S_HIGH
   } state_t;

   logic [WORD_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [AW:0]           r_count;

   state_t                r_state;
   state_t                w_state_next;
   logic [7:0]            r_hold_hi;
   logic                  r_tx_valid;
   logic [7:0]            r_tx_byte;
   logic                  r_word_sent;
   logic [WORD_WIDTH-1:0] r_sent_count;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_load;
   logic                  w_sent;
   logic [WORD_WIDTH-1:0] w_head;

   assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);
   // Fullness is judged on the registered count, so a same-cycle pop never
   // opens a slot for a push offered while full.
   assign w_push  = word_valid && !w_full;
   assign w_head  = r_mem[r_rd_ptr];

   assign word_ready      = !w_full;
   assign tx_byte_valid   = r_tx_valid;
   assign tx_byte         = r_tx_byte;
   assign word_sent       = r_word_sent;
   assign word_sent_count = r_sent_count;

   // FIFO storage: written on an accepted push, never reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= word_in;
      end
   end

   // FIFO pointers and occupancy; pops happen only on serializer loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_load) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_load})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Serializer state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Serializer next state, FIFO load and word-complete decisions.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_sent       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_load       = 1'b1;
               w_state_next = S_LOW;
            end
         end
         S_LOW: begin
            if (tx_byte_ready) begin
               w_state_next = S_HIGH;
            end
         end
         S_HIGH: begin
            if (tx_byte_ready) begin
               w_sent = 1'b1;
               if (!w_empty) begin
                  w_load       = 1'b1;
                  w_state_next = S_LOW;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Registered byte outputs, holding register and sent-word bookkeeping.
   // The low byte goes straight from the FIFO head to tx_byte on load, so
   // only the high byte needs to be held for the second beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_hi    <= '0;
         r_tx_valid   <= 1'b0;
         r_tx_byte    <= '0;
         r_word_sent  <= 1'b0;
         r_sent_count <= '0;
      end else begin
         r_tx_valid  <= (w_state_next != S_IDLE);
         r_word_sent <= w_sent;
         if (w_sent) begin
            r_sent_count <= r_sent_count + 1'b1;
         end
         if (w_load) begin
            r_hold_hi <= w_head[15:8];
            r_tx_byte <= w_head[7:0];
         end else if ((r_state == S_LOW) && tx_byte_ready) begin
            r_tx_byte <= r_hold_hi;
         end
      end
   end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: scenario tasks for uart_word_tx against a word-level model
// (each accepted word must appear as low byte then high byte, in order).
module tb_uart_word_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        word_valid;
   logic [15:0] word_in;
   logic        word_ready;
   logic        tx_byte_valid;
   logic [7:0]  tx_byte;
   logic        tx_byte_ready;
   logic        word_sent;
   logic [15:0] word_sent_count;

   int          checks = 0;
   int          errors = 0;

   logic [7:0]  obs_q[$];
   int          hs_cyc[$];
   logic [15:0] acc_q[$];
   int          cyc = 0;
   int          pulses = 0;
   int          stall_viol = 0;
   logic        prev_stall = 1'b0;
   logic [7:0]  stall_byte = '0;
   int          model_sent = 0;

   uart_word_tx #(.WORD_WIDTH(16), .FIFO_DEPTH(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .word_valid      (word_valid),
      .word_in         (word_in),
      .word_ready      (word_ready),
      .tx_byte_valid   (tx_byte_valid),
      .tx_byte         (tx_byte),
      .tx_byte_ready   (tx_byte_ready),
      .word_sent       (word_sent),
      .word_sent_count (word_sent_count)
   );

   always #5 clk = ~clk;

   // Advance one cycle: observe at the negedge, return 1 time unit after posedge.
   task automatic step();
      @(negedge clk);
      if (prev_stall && (!tx_byte_valid || tx_byte !== stall_byte)) stall_viol++;
      prev_stall = tx_byte_valid && !tx_byte_ready;
      stall_byte = tx_byte;
      if (tx_byte_valid && tx_byte_ready) begin
         obs_q.push_back(tx_byte);
         hs_cyc.push_back(cyc);
      end
      if (word_sent) pulses++;
      if (word_valid && word_ready) acc_q.push_back(word_in);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_obs();
      obs_q.delete();
      hs_cyc.delete();
      acc_q.delete();
      pulses     = 0;
      stall_viol = 0;
      prev_stall = 1'b0;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      word_valid    = 1'b0;
      tx_byte_ready = 1'b0;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      model_sent = 0;
      clear_obs();
   endtask

   task automatic drain(input int nb, input int budget, input bit rnd);
      int n = 0;
      while (obs_q.size() < nb && n < budget) begin
         tx_byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         step();
         n++;
      end
      tx_byte_ready = 1'b1;
      step();
      step();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (tx_byte_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", tx_byte_valid); end
      checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h want 00", tx_byte); end
      checks++; if (word_sent !== 1'b0) begin errors++; $display("FAIL reset_sent got %b want 0", word_sent); end
      checks++; if (word_sent_count !== 16'h0000) begin errors++; $display("FAIL reset_count got %h want 0000", word_sent_count); end
      checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", word_ready); end
   endtask

   task automatic test_single();
      logic [7:0] exp_b[2] = '{8'hEF, 8'hBE};
      clear_obs();
      tx_byte_ready = 1'b1;
      word_valid    = 1'b1;
      word_in       = 16'hBEEF;
      step();
      word_valid = 1'b0;
      checks++; if (tx_byte_valid !== 1'b0) begin errors++; $display("FAIL single_lat0 got %b want 0", tx_byte_valid); end
      step();
      checks++; if (tx_byte_valid !== 1'b1 || tx_byte !== 8'hEF) begin errors++; $display("FAIL single_lo got v=%b b=%h want v=1 b=ef", tx_byte_valid, tx_byte); end
      step();
      checks++; if (tx_byte_valid !== 1'b1 || tx_byte !== 8'hBE) begin errors++; $display("FAIL single_hi got v=%b b=%h want v=1 b=be", tx_byte_valid, tx_byte); end
      step();
      step();
      model_sent += 1;
      checks++; if (tx_byte_valid !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", tx_byte_valid); end
      checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL single_nbytes got %0d want 2", obs_q.size()); end
      else for (int i = 0; i < 2; i++) begin
         checks++; if (obs_q[i] !== exp_b[i]) begin errors++; $display("FAIL single_byte%0d got %h want %h", i, obs_q[i], exp_b[i]); end
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulses got %0d want 1", pulses); end
      checks++; if (word_sent_count !== 16'(model_sent)) begin errors++; $display("FAIL single_count got %h want %h", word_sent_count, 16'(model_sent)); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] w[3] = '{16'h1234, 16'h5678, 16'h9ABC};
      clear_obs();
      tx_byte_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         word_valid = 1'b1;
         word_in    = w[i];
         step();
      end
      word_valid = 1'b0;
      drain(6, 40, 1'b0);
      model_sent += 3;
      checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL b2b_nbytes got %0d want 6", obs_q.size()); end
      else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_q[i] !== ((i % 2 == 0) ? w[i/2][7:0] : w[i/2][15:8])) begin
               errors++; $display("FAIL b2b_byte%0d got %h want %h", i, obs_q[i], (i % 2 == 0) ? w[i/2][7:0] : w[i/2][15:8]);
            end
         end
         checks++; if (hs_cyc[5] - hs_cyc[0] != 5) begin errors++; $display("FAIL b2b_gapless got span %0d want 5", hs_cyc[5] - hs_cyc[0]); end
      end
      checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses got %0d want 3", pulses); end
      checks++; if (word_sent_count !== 16'(model_sent)) begin errors++; $display("FAIL b2b_count got %h want %h", word_sent_count, 16'(model_sent)); end
   endtask

   task automatic test_backpressure();
      clear_obs();
      tx_byte_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_before%0d got %b want 1", i, word_ready); end
         word_valid = 1'b1;
         word_in    = 16'(i);
         step();
      end
      word_in = 16'h0006;
      checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL bp_full got ready=%b want 0", word_ready); end
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (tx_byte_valid !== 1'b1 || tx_byte !== 8'h01) begin errors++; $display("FAIL bp_stall%0d got v=%b b=%h want v=1 b=01", k, tx_byte_valid, tx_byte); end
      end
      word_valid = 1'b0;
      checks++; if (acc_q.size() != 5) begin errors++; $display("FAIL bp_accepted got %0d want 5", acc_q.size()); end
      drain(10, 60, 1'b0);
      model_sent += 5;
      checks++; if (obs_q.size() != 10) begin errors++; $display("FAIL bp_nbytes got %0d want 10", obs_q.size()); end
      else for (int i = 0; i < 10; i++) begin
         checks++;
         if (obs_q[i] !== ((i % 2 == 0) ? 8'(i/2 + 1) : 8'h00)) begin
            errors++; $display("FAIL bp_byte%0d got %h want %h", i, obs_q[i], (i % 2 == 0) ? 8'(i/2 + 1) : 8'h00);
         end
      end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got %0d violations want 0", stall_viol); end
      checks++; if (word_sent_count !== 16'(model_sent)) begin errors++; $display("FAIL bp_count got %h want %h", word_sent_count, 16'(model_sent)); end
   endtask

   task automatic test_random_stalls();
      logic [15:0] w[8];
      int idx = 0;
      int n   = 0;
      clear_obs();
      for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
      while (idx < 8 && n < 300) begin
         word_valid    = 1'b1;
         word_in       = w[idx];
         tx_byte_ready = 1'($urandom_range(0, 1));
         step();
         if (acc_q.size() > idx) idx++;
         n++;
      end
      word_valid = 1'b0;
      drain(16, 400, 1'b1);
      model_sent += 8;
      checks++; if (obs_q.size() != 16) begin errors++; $display("FAIL rnd_nbytes got %0d want 16", obs_q.size()); end
      else for (int i = 0; i < 16; i++) begin
         checks++;
         if (obs_q[i] !== ((i % 2 == 0) ? w[i/2][7:0] : w[i/2][15:8])) begin
            errors++; $display("FAIL rnd_byte%0d got %h want %h", i, obs_q[i], (i % 2 == 0) ? w[i/2][7:0] : w[i/2][15:8]);
         end
      end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL rnd_stable got %0d violations want 0", stall_viol); end
      checks++; if (pulses != 8) begin errors++; $display("FAIL rnd_pulses got %0d want 8", pulses); end
      checks++; if (word_sent_count !== 16'(model_sent)) begin errors++; $display("FAIL rnd_count got %h want %h", word_sent_count, 16'(model_sent)); end
   endtask

   task automatic test_reset_mid_word();
      logic [15:0] w[3] = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
      clear_obs();
      tx_byte_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         word_valid = 1'b1;
         word_in    = w[i];
         step();
      end
      word_valid    = 1'b0;
      tx_byte_ready = 1'b1;
      step();
      tx_byte_ready = 1'b0;
      checks++; if (tx_byte_valid !== 1'b1 || tx_byte !== 8'hA1) begin errors++; $display("FAIL mid_high got v=%b b=%h want v=1 b=a1", tx_byte_valid, tx_byte); end
      do_reset();
      checks++; if (tx_byte_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", tx_byte_valid); end
      checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", word_ready); end
      checks++; if (word_sent_count !== 16'h0000) begin errors++; $display("FAIL mid_count got %h want 0000", word_sent_count); end
      tx_byte_ready = 1'b1;
      for (int k = 0; k < 8; k++) step();
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_quiet got %0d bytes want 0", obs_q.size()); end
      checks++; if (pulses != 0) begin errors++; $display("FAIL mid_pulses got %0d want 0", pulses); end
   endtask

   task automatic test_count_wrap();
      clear_obs();
      tx_byte_ready = 1'b1;
      force dut.r_sent_count = 16'hFFFF;
      step();
      release dut.r_sent_count;
      model_sent = 65535;
      checks++; if (word_sent_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %h want ffff", word_sent_count); end
      word_valid = 1'b1;
      word_in    = 16'h55AA;
      step();
      word_valid = 1'b0;
      drain(2, 20, 1'b0);
      model_sent += 1;
      checks++; if (word_sent_count !== 16'(model_sent)) begin errors++; $display("FAIL wrap_count got %h want %h", word_sent_count, 16'(model_sent)); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL wrap_pulses got %0d want 1", pulses); end
   endtask

   initial begin
      rst           = 1'b1;
      word_valid    = 1'b0;
      word_in       = '0;
      tx_byte_ready = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_random_stalls();
      test_reset_mid_word();
      test_count_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Transmit-side counterpart of the UART receive word assembler: accepts WORD_WIDTH-bit words from the core and serialises each into two bytes, low byte first, for the UART byte transmitter.
- Sits between the core/debug logic (word producer) and the UART byte-level TX shifter.
- Small word FIFO decouples the producer from the slow serial line; a running count of fully sent words is exported.

Parameters:
- WORD_WIDTH, 16, word width in bits; fixed at 16 (two bytes). Other values unsupported.
- FIFO_DEPTH, 4, word FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- word_valid  input  1  producer has a word on word_in.
- word_in  input  WORD_WIDTH  word to send.
- word_ready  output  1  FIFO can accept a word (= not full).
- tx_byte_valid  output  1  tx_byte holds a byte for the transmitter.
- tx_byte  output  8  byte to transmit.
- tx_byte_ready  input  1  transmitter takes tx_byte this cycle when tx_byte_valid is high.
- word_sent  output  1  one-cycle pulse when a word's high byte is accepted.
- word_sent_count  output  WORD_WIDTH  number of words fully sent since reset.

Behaviour:
- Reset (rst high at posedge): FIFO emptied, state IDLE, tx_byte_valid=0, tx_byte=0, word_sent=0, word_sent_count=0. word_ready reads 1 in the first cycle after the reset edge. Reset mid-word drops the in-flight word and all queued words; there is no partial-word recovery.
- Push: word written when word_valid && word_ready at posedge. word_ready = !full, combinational from the registered count. A push offered while the FIFO is full is not accepted, even if a pop occurs in the same cycle.
- Pop: occurs only on a serializer load. Simultaneous push and pop is legal whenever not full; the count is unchanged in that case.
- FIFO pointers wrap modulo FIFO_DEPTH. The count ranges 0..FIFO_DEPTH.
- Serializer FSM, registered state:
  - IDLE: tx_byte_valid=0. If the FIFO is non-empty, load the head into the holding register, pop, and go to LOW.
  - LOW: tx_byte_valid=1, tx_byte=hold[7:0]. On tx_byte_ready, go to HIGH. Otherwise stay, with tx_byte stable.
  - HIGH: tx_byte_valid=1, tx_byte=hold[15:8]. On tx_byte_ready: pulse word_sent for one cycle and increment word_sent_count.
    - If the FIFO is non-empty (judged on the pre-edge count), load and pop the next word and go to LOW. This gives back-to-back bytes with no idle cycle.
    - Otherwise go to IDLE.
- tx_byte and tx_byte_valid are registered outputs and never change while valid is high and ready is low.
- Latency: a word pushed at edge E0 into an empty FIFO with the FSM in IDLE is loaded at E1. tx_byte_valid is high from E1.
- Minimum 2 cycles per word when tx_byte_ready is held high.
- word_sent_count wraps 0xFFFF -> 0x0000 without flagging.
- tx_byte_ready while tx_byte_valid is low is ignored.

Test Plan:
- Single word: reset, push 0xBEEF, tx_byte_ready=1 -> tx_byte_valid rises one cycle after the push edge; bytes 0xEF then 0xBE on consecutive cycles; one word_sent pulse; word_sent_count=1; FSM returns to IDLE.
- Back-to-back: push 0x1234, 0x5678, 0x9ABC with ready=1 -> byte stream 34 12 78 56 BC 9A with no gaps in tx_byte_valid; word_sent_count=3.
- Backpressure and full: ready=0, push 5 words 0x0001..0x0005 ->
  - 0x0001 loaded into the FSM, 0x0002..0x0005 fill the FIFO, word_ready=0;
  - a sixth push is refused;
  - tx_byte stays 0x01 while stalled;
  - with ready=1, the output is 01 00 02 00 03 00 04 00 05 00.
- Random ready stalls: 8 words, ready toggled pseudo-randomly -> byte order and values match, tx_byte is stable during stalls, word_sent pulses=8.
- Reset mid-word: assert rst while in HIGH with 2 words queued -> next cycle tx_byte_valid=0, word_ready=1, count=0; no further bytes until a new push.
- Count wrap: force or preload 65535 sent words (or shorten the count in sim) -> after the next word, word_sent_count=0x0000.
